// File: rtl/hlsm_array_loader_if.sv
// Stream-in, register-file write and engine handshake bundle for the array loader.
// slave = loader side, master = stream source / register file / engine side.
interface hlsm_array_loader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              W_en;
    logic [ADDR_W-1:0] W_Addr;
    logic [DATA_W-1:0] W_Data;
    logic              go;
    logic              eng_done;

    modport slave (
        input  in_valid, in_data, eng_done,
        output in_ready, W_en, W_Addr, W_Data, go
    );

    modport master (
        output in_valid, in_data, eng_done,
        input  in_ready, W_en, W_Addr, W_Data, go
    );
endinterface

// File: rtl/hlsm_array_loader.sv
// Loads a DEPTH-byte frame into the max/min engine register file, kicks the engine, reports completion.
// Latency: accepted byte written 1 cycle later; go 1 cycle after the last write; frame_done 1 cycle after eng_done.
// Backpressure: in_ready high only while loading; optional checksum enabled by LOADER_CHECKSUM_EN.
module hlsm_array_loader #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                start,
    input  logic                abort,
    hlsm_array_loader_if.slave  lif,
    output logic                busy,
    output logic [ADDR_W:0]     load_count,
    output logic                frame_done,
    output logic [DATA_W-1:0]   checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KICK,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

    state_t              state_q, state_d;
    logic                w_en_q, w_en_d;
    logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
    logic [DATA_W-1:0]   w_data_q, w_data_d;
    logic                go_q, go_d;
    logic                frame_done_q, frame_done_d;
    logic [ADDR_W:0]     load_count_q, load_count_d;
    logic                accept;
    logic                frame_start;

    assign lif.in_ready = (state_q == S_LOAD);
    assign busy         = (state_q != S_IDLE);

    // abort outranks a simultaneous byte: no write, no count change
    assign accept      = (state_q == S_LOAD) && lif.in_valid && !abort;
    assign frame_start = (state_q == S_IDLE) && start;

    always_comb begin
        state_d      = state_q;
        w_en_d       = 1'b0;
        w_addr_d     = w_addr_q;
        w_data_d     = w_data_q;
        go_d         = 1'b0;
        frame_done_d = 1'b0;
        load_count_d = load_count_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_LOAD;
                    load_count_d = '0;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (accept) begin
                    w_en_d       = 1'b1;
                    w_addr_d     = load_count_q[ADDR_W-1:0];
                    w_data_d     = lif.in_data;
                    load_count_d = load_count_q + CNT_ONE;
                    if (load_count_q == LAST_CNT) begin
                        state_d = S_KICK;
                    end
                end
            end
            S_KICK: begin
                go_d    = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // the engine cannot be cancelled, so abort is not looked at here
                if (lif.eng_done) begin
                    state_d      = S_DONE;
                    frame_done_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= S_IDLE;
            w_en_q       <= 1'b0;
            w_addr_q     <= '0;
            w_data_q     <= '0;
            go_q         <= 1'b0;
            frame_done_q <= 1'b0;
            load_count_q <= '0;
        end else begin
            state_q      <= state_d;
            w_en_q       <= w_en_d;
            w_addr_q     <= w_addr_d;
            w_data_q     <= w_data_d;
            go_q         <= go_d;
            frame_done_q <= frame_done_d;
            load_count_q <= load_count_d;
        end
    end

    assign lif.W_en   = w_en_q;
    assign lif.W_Addr = w_addr_q;
    assign lif.W_Data = w_data_q;
    assign lif.go     = go_q;
    assign frame_done = frame_done_q;
    assign load_count = load_count_q;

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;

    // partial sum survives an abort; only a new frame clears it
    always_comb begin
        sum_d = sum_q;
        if (frame_start) begin
            sum_d = '0;
        end else if (accept) begin
            sum_d = sum_q + lif.in_data;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    logic unused_frame_start;
    assign unused_frame_start = frame_start;
    assign checksum           = '0;
`endif

endmodule

// File: doc/hlsm_array_loader.md
Name: hlsm_array_loader

Overview:
- Upstream stage of the max/min difference engine.
- Accepts a frame of DEPTH bytes over a valid/ready stream and writes them in order into the engine's 256x8 register file write port.
- Then pulses go to the engine and waits for the engine's done.
- Signals frame completion to the system controller.

Parameters:
- DEPTH, 256, number of bytes per frame; one per register-file entry.
- DATA_W, 8, stream and register-file data width.
- ADDR_W, 8, register-file address width; DEPTH must equal 2**ADDR_W.

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Rst  input  1  asynchronous, active-low reset.
- start  input  1  begin a frame; sampled only in S_IDLE.
- abort  input  1  synchronous abandon of the current frame.
- in_valid  input  1  stream byte present.
- in_data  input  DATA_W  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- W_en  output  1  register-file write enable.
- W_Addr  output  ADDR_W  register-file write address.
- W_Data  output  DATA_W  register-file write data.
- go  output  1  start pulse to the max/min engine.
- eng_done  input  1  done pulse from the max/min engine.
- busy  output  1  high in every state except S_IDLE.
- load_count  output  ADDR_W+1  bytes accepted in the current frame, 0..DEPTH.
- frame_done  output  1  one-cycle pulse when the engine has finished.
- checksum  output  DATA_W  frame checksum (see Optional Feature).

Behaviour:
- Reset (Rst=0, asynchronous):
  - State returns to S_IDLE.
  - W_en, W_Addr, W_Data, go, frame_done, load_count, checksum all go to 0.
  - Register-file contents are not cleared.
- Outputs:
  - in_ready and busy are decoded combinationally from state.
  - W_*, go and frame_done are registered.
- States and transitions:
  - S_IDLE: in_ready=0. start=1 -> S_LOAD and load_count<=0. Otherwise stay.
  - S_LOAD: in_ready=1.
    - On accept (in_valid & in_ready), the next cycle has W_en=1, W_Addr=load_count[ADDR_W-1:0], W_Data=in_data, and load_count is incremented. Write latency is exactly 1 cycle.
    - If the accept happens with load_count==DEPTH-1 -> S_KICK.
    - abort=1 -> S_IDLE with no write for that cycle, even if in_valid=1 (abort has priority over accept).
  - S_KICK: go=1 for exactly one cycle -> S_WAIT. The last write (W_en) lands in the same cycle the state enters S_KICK, so go follows the final write by 1 cycle.
  - S_WAIT: in_ready=0. eng_done=1 -> S_DONE. abort is ignored because the engine cannot be cancelled.
  - S_DONE: frame_done=1 for one cycle -> S_IDLE. load_count holds DEPTH until the next start.
- W_en is 0 in every cycle not following an accept. No back-to-back gaps are required: one byte per cycle is sustained.
- start outside S_IDLE is ignored. in_valid outside S_LOAD is ignored (no write, no count change).
- load_count is ADDR_W+1 bits and never wraps: S_LOAD is left before it exceeds DEPTH.
- Simultaneous events:
  - start and abort together in S_IDLE: start wins, and abort is evaluated from the next cycle.
  - eng_done arriving in any state other than S_WAIT is ignored.
- Reset mid-frame: the frame is discarded and the partially written array is left as-is; the next start overwrites from address 0.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - checksum is an 8-bit modulo-256 sum of every accepted in_data byte.
  - It is cleared on the start accept and updated in the cycle after each accept.
  - Its value is final and stable from S_KICK through the next start.
  - abort leaves the partial sum visible.
- Not defined: checksum is tied to 0 and no adder is synthesised.

Test Plan:
- Reset then start, stream bytes 0..255 back-to-back:
  - 256 writes, W_Addr==W_Data each cycle.
  - go pulses 1 cycle after the write to address 255.
  - With eng_done returned 5 cycles later, frame_done pulses 1 cycle after eng_done.
  - With the engine attached, max_diff=255.
- Start, stream with in_valid toggling every other cycle, bytes all 0x10 except address 77=0x90:
  - Exactly 256 writes, no write on idle cycles.
  - load_count=256 at S_KICK.
  - Engine result 0x80.
- Start, accept 100 bytes, then abort with in_valid=1:
  - No write in the abort cycle; back to S_IDLE.
  - busy=0, load_count=100.
  - A new start restarts at W_Addr 0.
- Assert Rst=0 asynchronously mid-frame at byte 40:
  - All outputs 0 immediately without waiting for a clock.
  - start after release loads a full frame correctly.
- Pulse start and eng_done while in S_LOAD and S_WAIT respectively, with eng_done early in S_LOAD:
  - Early eng_done is ignored.
  - Second start is ignored.
  - Only one go and one frame_done per frame.
- With LOADER_CHECKSUM_EN, bytes i*3 mod 256 for i=0..255: checksum=0x80 at S_KICK. Without the macro, checksum stays 0.
